// File: rtl/layer3_feature_streamer.sv
// Replays a filled feature BRAM PASSES times as an AXI-Stream, then releases the buffer.
// BRAM reads are throttled so the output register plus skid can always absorb in-flight words.
module layer3_feature_streamer #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int NWORDS = 128,
    parameter int PASSES = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              full_flag,
    input  logic              full_flag_ap_vld,
    output logic              full_flag_ap_ack,
    output logic [ADDR_W-1:0] f_Data_address0,
    output logic              f_Data_ce0,
    input  logic [DATA_W-1:0] f_Data_q0,
    output logic [DATA_W-1:0] a_Data_TDATA,
    output logic              a_Data_TVALID,
    input  logic              a_Data_TREADY,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NWORDS - 1);
    localparam logic [8:0]        LAST_PASS = 9'(PASSES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic [8:0]          pass_q, pass_d;
    logic                issued_all_q, issued_all_d;
    logic                rd_pend_q;
    logic                out_v_q, out_v_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                skid_v_q, skid_v_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic [1:0]          occ;
    logic                pop, issue, accept, last_xfer;

    // Stream handshake: a word moves on any cycle with TVALID=1 and TREADY=1; while
    // TVALID=1 and TREADY=0 the head word (and TDATA) stays put. A word landing from the
    // BRAM is presented directly when the output register is empty, otherwise it queues.
    assign a_Data_TVALID = out_v_q | rd_pend_q;
    assign a_Data_TDATA  = out_v_q ? out_data_q : f_Data_q0;
    assign pop           = a_Data_TVALID & a_Data_TREADY;

    assign occ       = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, rd_pend_q};
    assign issue     = (state_q == STREAM) && !issued_all_q && ((occ - {1'b0, pop}) <= 2'd1);
    assign last_xfer = issued_all_q && pop && (occ == 2'd1);
    assign accept    = (state_q == IDLE) && full_flag_ap_vld && full_flag;

    assign f_Data_ce0       = issue;
    assign f_Data_address0  = issue ? addr_q : last_addr_q;
    assign full_flag_ap_ack = (state_q == RELEASE);
    assign busy             = (state_q != IDLE);
    assign dbg_state_o      = state_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        last_addr_d  = last_addr_q;
        pass_d       = pass_q;
        issued_all_d = issued_all_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = STREAM;
                    addr_d       = '0;
                    pass_d       = '0;
                    issued_all_d = 1'b0;
                end
            end
            STREAM: begin
                if (issue) begin
                    last_addr_d = addr_q;
                    if (addr_q == LAST_ADDR) begin
                        addr_d = '0;
                        pass_d = pass_q + 9'd1;
                        if (pass_q == LAST_PASS) begin
                            issued_all_d = 1'b1;
                        end
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (last_xfer) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Occupancy is capped at two, so skid and an in-flight word never coexist with a full head.
    always_comb begin
        out_v_d     = out_v_q;
        out_data_d  = out_data_q;
        skid_v_d    = skid_v_q;
        skid_data_d = skid_data_q;
        if (pop) begin
            if (out_v_q) begin
                if (skid_v_q) begin
                    out_data_d = skid_data_q;
                    skid_v_d   = 1'b0;
                end else begin
                    out_v_d    = rd_pend_q;
                    out_data_d = f_Data_q0;
                end
            end else begin
                out_v_d = 1'b0;
            end
        end else if (rd_pend_q) begin
            if (out_v_q) begin
                skid_v_d    = 1'b1;
                skid_data_d = f_Data_q0;
            end else begin
                out_v_d    = 1'b1;
                out_data_d = f_Data_q0;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            last_addr_q  <= '0;
            pass_q       <= '0;
            issued_all_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            out_v_q      <= 1'b0;
            out_data_q   <= '0;
            skid_v_q     <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            last_addr_q  <= last_addr_d;
            pass_q       <= pass_d;
            issued_all_q <= issued_all_d;
            rd_pend_q    <= f_Data_ce0;
            out_v_q      <= out_v_d;
            out_data_q   <= out_data_d;
            skid_v_q     <= skid_v_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: doc/layer3_feature_streamer.md
LAYER3_FEATURE_STREAMER -- requirements
Module: layer3_feature_streamer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 128: width of one feature word and of the stream data.
REQ-002 The module SHALL have parameter ADDR_W, default 7: feature BRAM address width.
REQ-003 The module SHALL have parameter NWORDS, default 128: number of words in one filled buffer, range 1..2^ADDR_W.
REQ-004 The module SHALL have parameter PASSES, default 16: number of complete replays of the buffer per fill, range 1..256.
REQ-005 The module SHALL have port ap_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The module SHALL have port ap_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port full_flag, input, 1 bit: the writer reports the buffer as filled.
REQ-008 The module SHALL have port full_flag_ap_vld, input, 1 bit: full_flag is valid; the writer holds it high until ack.
REQ-009 The module SHALL have port full_flag_ap_ack, output, 1 bit: one-cycle pulse releasing the buffer back to the writer.
REQ-010 The module SHALL have port f_Data_address0, output, ADDR_W bits: BRAM read address.
REQ-011 The module SHALL have port f_Data_ce0, output, 1 bit: BRAM read enable.
REQ-012 The module SHALL have port f_Data_q0, input, DATA_W bits: BRAM read data, valid exactly 1 cycle after a ce0 cycle.
REQ-013 The module SHALL have port a_Data_TDATA, output, DATA_W bits: AXI-Stream feature data to the MAC tree.
REQ-014 The module SHALL have port a_Data_TVALID, output, 1 bit: stream valid.
REQ-015 The module SHALL have port a_Data_TREADY, input, 1 bit: stream ready.
REQ-016 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, STREAM and RELEASE.
REQ-018 In IDLE, a cycle with full_flag_ap_vld=1 and full_flag=1 SHALL cause the next state to be STREAM. In IDLE, vld=1 with full_flag=0 SHALL be ignored: no ack is sent and the state stays IDLE.
REQ-019 In STREAM, the block SHALL issue BRAM reads with addresses 0..NWORDS-1, in order, once per pass, for PASSES passes. The address SHALL wrap from NWORDS-1 to 0 at each pass boundary, and the pass counter SHALL increment at the same time.
REQ-020 A read SHALL be issued (ce0=1) only when the 2-entry output buffer (output register plus skid) can hold that word, counting reads already in flight. No word SHALL ever be dropped or duplicated under any TREADY pattern.
REQ-021 Transfer rule: a word transfers on a cycle where TVALID and TREADY are both 1. TDATA and TVALID SHALL hold stable while TVALID=1 and TREADY=0.
REQ-022 Throughput: with TREADY held at 1, the block SHALL sustain one word per cycle, including across pass boundaries.
REQ-023 Latency: if the handshake is accepted on cycle T, the first ce0 SHALL be on T+1 and the first TVALID SHALL be on T+2.
REQ-024 Once the final word (address NWORDS-1 of pass PASSES-1) transfers, the next state SHALL be RELEASE.
REQ-025 RELEASE SHALL last one cycle: full_flag_ap_ack=1 for exactly that cycle, then the state returns to IDLE.
REQ-026 A new handshake SHALL be accepted no earlier than the cycle after RELEASE.
REQ-027 Stream word order SHALL equal the BRAM address order. Word k of each pass SHALL equal BRAM[k].
REQ-028 f_Data_address0 SHALL hold its last value whenever ce0=0. There SHALL be no reads outside the STREAM state.
REQ-029 Total transfers per fill SHALL equal NWORDS*PASSES exactly. The counters SHALL be sized so that PASSES=256 with NWORDS=128 does not overflow.

Reset
REQ-030 While ap_rst=1 on a clock edge, the block SHALL go to the following state next cycle: state IDLE; TVALID, ce0 and full_flag_ap_ack 0; address, pass counter and skid buffer cleared; busy 0.
REQ-031 Reset during STREAM SHALL abort the stream with no ack sent. Words in flight SHALL be discarded, and TVALID SHALL be 0 on the cycle after reset is sampled.
REQ-032 After reset deasserts, a vld that is still high SHALL be treated as a new handshake.

Verification
REQ-033 Nominal run. Stimulus: NWORDS=4, PASSES=2, BRAM[k]=k+1, TREADY=1, vld/full_flag asserted on cycle 10. Required response: TVALID on cycles 12..19 with data 1,2,3,4,1,2,3,4; ack on cycle 20 only.
REQ-034 Backpressure. Stimulus: same setup, TREADY toggling 1,0,0,1 repeatedly. Required response: exactly 8 transfers in order 1,2,3,4,1,2,3,4; TDATA stable across every stall; ack once, after the 8th transfer.
REQ-035 Ignored handshake. Stimulus: vld=1 with full_flag=0 for 5 cycles. Required response: no ce0, no TVALID, no ack; busy stays 0.
REQ-036 Reset mid-stream. Stimulus: ap_rst=1 after the 3rd transfer. Required response: TVALID=0 next cycle, no ack; with vld still high after reset, the stream restarts at word BRAM[0].
REQ-037 Boundary. Stimulus: NWORDS=1, PASSES=1, TREADY=0 for 10 cycles then 1. Required response: a single word held stable for those 10 cycles; ack exactly 1 cycle after it transfers.
REQ-038 Back-to-back. Stimulus: vld re-asserted on the cycle immediately after ack. Required response: the second fill streams with first TVALID 2 cycles after its acceptance, and the total count equals 2*NWORDS*PASSES.
